// File: rtl/seven_segment_bcd_display.sv
// Binary-to-decimal seven-segment driver: iterative double-dabble conversion (one shift per clock),
// leading-zero blanking, overflow dashes and whole-display blinking. Segments are active low.
module seven_segment_bcd_display #(
  parameter int BIN_WIDTH  = 7,
  parameter int NUM_DIGITS = 2,
  parameter int BLINK_DIV  = 12_500_000
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic [BIN_WIDTH-1:0]    i_Value,
  input  logic                    i_Load,
  input  logic                    i_Blank_Lz,
  input  logic                    i_Blink_En,
  output logic                    o_Busy,
  output logic                    o_Done,
  output logic                    o_Overflow,
  output logic [7*NUM_DIGITS-1:0] o_Segments
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  localparam int          BCD_W = 4 * NUM_DIGITS;
  localparam int          SEG_W = 7 * NUM_DIGITS;
  localparam int          CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int          BLK_W = $clog2(BLINK_DIV);
  localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);
  localparam logic [6:0]  DASH  = 7'b0111111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d, bin_sh;
  logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj, bcd_sh;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_pend_q, ovf_pend_d, ovf_q, ovf_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [SEG_W-1:0]     disp_q, disp_d, disp_new, seg_q, seg_d;
  logic [BLK_W-1:0]     blk_q, blk_d;
  logic                 phase_on_q, phase_on_d;
  logic                 lz;
  logic [3:0]           nib;

  always_comb begin
    // Add-3 correction on every nibble, then shift {bcd,bin} left by one.
    bcd_adj = bcd_q;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    bcd_sh = {bcd_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
    bin_sh = {bin_q[BIN_WIDTH-2:0], 1'b0};

    // Digits from the final shift; walk down from the top blanking zeros until a nonzero digit.
    disp_new = '1;
    lz       = i_Blank_Lz;
    nib      = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib = bcd_sh[4*k +: 4];
      if (ovf_pend_q) begin
        disp_new[7*k +: 7] = DASH;
      end else if (lz && nib == 4'd0 && k != 0) begin
        disp_new[7*k +: 7] = 7'b1111111;
      end else begin
        disp_new[7*k +: 7] = seg_dec(nib);
        lz                 = 1'b0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    disp_d     = disp_q;
    case (state_q)
      S_IDLE: if (i_Load) begin
        bin_d      = i_Value;
        bcd_d      = '0;
        cnt_d      = '0;
        ovf_pend_d = 64'(i_Value) >= LIMIT;
        busy_d     = 1'b1;
        state_d    = S_SHIFT;
      end
      S_SHIFT: begin
        bin_d = bin_sh;
        bcd_d = bcd_sh;
        cnt_d = cnt_q + 1'b1;
        // Last shift: publish digits so they are visible during the DONE cycle.
        if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          ovf_d   = ovf_pend_q;
          disp_d  = disp_new;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    blk_d      = '0;
    phase_on_d = 1'b1;
    if (i_Blink_En) begin
      if (blk_q == BLK_W'(BLINK_DIV - 1)) begin
        blk_d      = '0;
        phase_on_d = ~phase_on_q;
      end else begin
        blk_d      = blk_q + 1'b1;
        phase_on_d = phase_on_q;
      end
    end
    seg_d = phase_on_d ? disp_d : '1;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      disp_q     <= '1;
      seg_q      <= '1;
      blk_q      <= '0;
      phase_on_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      disp_q     <= disp_d;
      seg_q      <= seg_d;
      blk_q      <= blk_d;
      phase_on_q <= phase_on_d;
    end
  end

  assign o_Busy     = busy_q;
  assign o_Done     = done_q;
  assign o_Overflow = ovf_q;
  assign o_Segments = seg_q;

endmodule

// File: tb/tb_seven_segment_bcd_display.sv
// Scoreboard bench: expected digits/overflow/done-cycle queued at each load, checked at o_Done.
module tb_seven_segment_bcd_display;

  localparam int BW = 7;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic [6:0]  i_Value = '0;
  logic        i_Load = 1'b0;
  logic        i_Blank_Lz = 1'b0;
  logic        i_Blink_En = 1'b0;
  logic        o_Busy, o_Done, o_Overflow;
  logic [13:0] o_Segments;

  seven_segment_bcd_display #(.BIN_WIDTH(BW), .NUM_DIGITS(2), .BLINK_DIV(4)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Value(i_Value), .i_Load(i_Load),
    .i_Blank_Lz(i_Blank_Lz), .i_Blink_En(i_Blink_En), .o_Busy(o_Busy),
    .o_Done(o_Done), .o_Overflow(o_Overflow), .o_Segments(o_Segments)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic [13:0] segs;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0, bad = 0;
  int          cyc = 0, ndone = 0, nbusy = 0;
  logic [13:0] last_segs = '1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] dig(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [13:0] exp_segs(input int v, input bit blank);
    logic [6:0] hi;
    if (v >= 100) return {7'b0111111, 7'b0111111};
    hi = (blank && v / 10 == 0) ? 7'b1111111 : dig(v / 10);
    return {hi, dig(v % 10)};
  endfunction

  always @(posedge i_Clk) cyc <= cyc + 1;

  always @(negedge i_Clk) begin
    if (o_Busy) nbusy++;
    if (o_Done) begin
      ndone++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("segs", 32'(o_Segments), 32'(e.segs));
        chk("ovf", 32'(o_Overflow), 32'(e.ovf));
        chk("done_cycle", cyc, e.cyc);
        last_segs = e.segs;
      end
    end
  end

  task automatic do_load(input int v, input bit blank);
    exp_t e;
    @(negedge i_Clk);
    i_Value    = 7'(v);
    i_Load     = 1'b1;
    i_Blank_Lz = blank;
    e.segs = exp_segs(v, blank);
    e.ovf  = (v >= 100);
    e.cyc  = cyc + BW + 1;
    sb.push_back(e);
    @(negedge i_Clk);
    i_Load = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int start;
    start = ndone;
    for (int i = 0; i < 30 && ndone == start; i++) begin
      @(negedge i_Clk);
      #1;
    end
    chk(tag, 32'(ndone != start), 32'd1);
  endtask

  initial begin
    int b0, d0, v;
    bit bl;
    repeat (3) @(negedge i_Clk);
    #1;
    chk("rst_busy", 32'(o_Busy), 32'd0);
    chk("rst_done", 32'(o_Done), 32'd0);
    chk("rst_ovf", 32'(o_Overflow), 32'd0);
    chk("rst_segs", 32'(o_Segments), 32'h3FFF);
    i_Rst = 1'b0;

    b0 = nbusy;
    do_load(42, 1'b0);
    wait_done("t1_done");
    repeat (3) @(negedge i_Clk);
    chk("t1_busy_cycles", nbusy - b0, 8);

    do_load(7, 1'b1);  wait_done("t2_a");
    do_load(7, 1'b0);  wait_done("t2_b");
    do_load(0, 1'b1);  wait_done("t2_c");
    do_load(10, 1'b1); wait_done("t2_d");
    do_load(99, 1'b1); wait_done("t3_a");
    do_load(100, 1'b0); wait_done("t3_b");
    do_load(127, 1'b1); wait_done("t3_c");
    for (int i = 0; i < 6; i++) begin
      v  = int'($urandom_range(127, 0));
      bl = 1'($urandom_range(1, 0));
      do_load(v, bl);
      wait_done("rand_done");
    end
    repeat (5) @(negedge i_Clk);
    #1;
    chk("hold", 32'(o_Segments), 32'(last_segs));

    // Load during busy is ignored: only one done, still 42.
    d0 = ndone;
    do_load(42, 1'b1);
    @(negedge i_Clk);
    @(negedge i_Clk);
    i_Value = 7'd13;
    i_Load  = 1'b1;
    @(negedge i_Clk);
    i_Load  = 1'b0;
    repeat (15) @(negedge i_Clk);
    chk("t4_single_done", ndone - d0, 1);

    // Reset mid-conversion aborts without a done.
    do_load(55, 1'b1);
    repeat (3) @(negedge i_Clk);
    i_Rst = 1'b1;
    @(negedge i_Clk);
    #1;
    chk("t5_busy", 32'(o_Busy), 32'd0);
    chk("t5_done", 32'(o_Done), 32'd0);
    chk("t5_ovf", 32'(o_Overflow), 32'd0);
    chk("t5_segs", 32'(o_Segments), 32'h3FFF);
    i_Rst = 1'b0;
    sb.delete();
    d0 = ndone;
    repeat (15) @(negedge i_Clk);
    chk("t5_no_done", ndone - d0, 0);
    do_load(42, 1'b1);
    wait_done("t5_reload");

    // Blink with BLINK_DIV=4.
    @(negedge i_Clk);
    i_Blink_En = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge i_Clk);
      #1;
      chk("blink", 32'(o_Segments),
          (k < 3 || (k >= 7 && k < 11)) ? 32'(exp_segs(42, 1'b1)) : 32'h3FFF);
    end
    i_Blink_En = 1'b0;
    @(negedge i_Clk);
    #1;
    chk("blink_off", 32'(o_Segments), 32'(exp_segs(42, 1'b1)));
    repeat (6) @(negedge i_Clk);
    #1;
    chk("blink_off_hold", 32'(o_Segments), 32'(exp_segs(42, 1'b1)));
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
